// File: rtl/program_encoder.sv
// rtl/program_encoder.sv - packs symbolic instruction tokens into 8-bit words and loads them into instruction memory
module program_encoder #(
    parameter int IMEM_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_mnem,
    input  logic               in_reg,
    input  logic [3:0]         in_addr,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [7:0]         imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [IMEM_AW:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [IMEM_AW-1:0] PTR_MAX = '1;
    localparam logic [IMEM_AW-1:0] PTR_ONE = 1;
    localparam logic [IMEM_AW:0]   CNT_ONE = 1;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] ptr_q, ptr_d;
    logic [IMEM_AW:0]   count_q, count_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [7:0]         imem_wdata_q, imem_wdata_d;
    logic [1:0]         err_code_q, err_code_d;

    logic               legal;
    logic               is_halt;
    logic [7:0]         word;

    // Token encoder: opcode in [7:4], operand in [3:0]; bit 7 doubles as register select for LOAD/STORE.
    always_comb begin
        legal   = 1'b1;
        is_halt = 1'b0;
        word    = 8'h00;
        case (in_mnem)
            4'd0:                         word = 8'h00;
            4'd1:                         word = {in_reg, 3'b001, in_addr};
            4'd2:                         word = {in_reg, 3'b010, in_addr};
            4'd3, 4'd4, 4'd5, 4'd6, 4'd7: word = {in_mnem, 4'h0};
            4'd8: begin
                word    = 8'hF0;
                is_halt = 1'b1;
            end
            default:                      legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        err_code_d   = err_code_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    if (!legal) begin
                        state_d    = S_ERROR;
                        err_code_d = 2'd1;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ptr_q;
                        imem_wdata_d = word;
                        count_d      = count_q + CNT_ONE;
                        if (is_halt) begin
                            state_d = S_DONE;
                        end else if (ptr_q == PTR_MAX) begin
                            state_d    = S_ERROR;
                            err_code_d = 2'd2;
                        end else begin
                            ptr_d = ptr_q + PTR_ONE;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d    = S_LOAD;
                    ptr_d      = '0;
                    count_d    = '0;
                    err_code_d = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 8'h00;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            err_code_q   <= err_code_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERROR);
    assign err_code   = err_code_q;
    assign count      = count_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;

endmodule

// File: tb/tb_program_encoder.sv
// tb/tb_program_encoder.sv - directed self-checking bench for program_encoder
module tb_program_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_mnem = 4'd0;
    logic       in_reg = 1'b0;
    logic [3:0] in_addr = 4'd0;
    logic       imem_we;
    logic [3:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [4:0] count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int next_addr = 0;

    int wa[$];
    int wd[$];
    int wc[$];
    int ea[$];
    int ed[$];
    int ec[$];

    program_encoder #(.IMEM_AW(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_reg(in_reg), .in_addr(in_addr),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(int'(imem_addr));
            wd.push_back(int'(imem_wdata));
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_test();
        wa.delete(); wd.delete(); wc.delete();
        ea.delete(); ed.delete(); ec.delete();
        next_addr = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic tok(input logic [3:0] m, input logic r, input logic [3:0] a,
                       input logic [7:0] exp_word, input bit writes);
        in_valid = 1'b1;
        in_mnem  = m;
        in_reg   = r;
        in_addr  = a;
        if (writes) begin
            ea.push_back(next_addr);
            ed.push_back(int'(exp_word));
            ec.push_back(cyc + 1);
            next_addr++;
        end
        step();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic verify_writes(input string tag);
        check({tag, ".nwrites"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), wa[i], ea[i]);
            check($sformatf("%s.data%0d", tag, i), wd[i], ed[i]);
            check($sformatf("%s.cyc%0d", tag, i), wc[i], ec[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"}, in_ready, 0);
        check({tag, ".imem_we"}, imem_we, 0);
        check({tag, ".imem_addr"}, imem_addr, 0);
        check({tag, ".imem_wdata"}, imem_wdata, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".err_code"}, err_code, 0);
        check({tag, ".count"}, count, 0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check_all_zero("reset");

        // T1: back-to-back stream ending in HALT
        begin_test();
        do_start();
        check("t1.busy", busy, 1);
        check("t1.in_ready", in_ready, 1);
        tok(4'd1, 1'b0, 4'd3, 8'h13, 1);
        tok(4'd1, 1'b1, 4'd4, 8'h94, 1);
        tok(4'd3, 1'b1, 4'd9, 8'h30, 1);
        tok(4'd2, 1'b0, 4'd5, 8'h25, 1);
        tok(4'd8, 1'b0, 4'd0, 8'hF0, 1);
        idle_in();
        check("t1.we_final", imem_we, 1);
        check("t1.done", done, 1);
        check("t1.busy_end", busy, 0);
        check("t1.ready_end", in_ready, 0);
        check("t1.count", count, 5);
        step();
        check("t1.we_after", imem_we, 0);
        check("t1.hold_addr", imem_addr, 4);
        check("t1.hold_data", imem_wdata, 8'hF0);
        // token in DONE has no effect
        tok(4'd3, 1'b0, 4'd0, 8'h00, 0);
        idle_in();
        step();
        verify_writes("t1");
        check("t1.count_hold", count, 5);

        // T2: in_valid every other cycle; token offered with start is ignored
        begin_test();
        in_valid = 1'b1;
        in_mnem  = 4'd8;
        do_start();
        tok(4'd4, 1'b0, 4'd0, 8'h40, 1);
        idle_in(); step();
        tok(4'd7, 1'b1, 4'd15, 8'h70, 1);
        idle_in(); step();
        tok(4'd8, 1'b0, 4'd0, 8'hF0, 1);
        idle_in();
        check("t2.done", done, 1);
        check("t2.count", count, 3);
        step(); step();
        verify_writes("t2");

        // T3: NOP then illegal mnemonic 12
        begin_test();
        do_start();
        check("t3.count_clr", count, 0);
        check("t3.done_clr", done, 0);
        tok(4'd0, 1'b0, 4'd0, 8'h00, 1);
        tok(4'd12, 1'b0, 4'd0, 8'h00, 0);
        idle_in();
        check("t3.we", imem_we, 0);
        check("t3.err", err, 1);
        check("t3.err_code", err_code, 1);
        check("t3.busy", busy, 0);
        check("t3.count", count, 1);
        check("t3.in_ready", in_ready, 0);
        step();
        verify_writes("t3");

        // T4: 16 AND tokens overflow memory
        begin_test();
        do_start();
        check("t4.err_clr", err, 0);
        check("t4.err_code_clr", err_code, 0);
        for (int i = 0; i < 16; i++) tok(4'd5, 1'b1, 4'd7, 8'h50, 1);
        idle_in();
        check("t4.we16", imem_we, 1);
        check("t4.addr16", imem_addr, 15);
        check("t4.err", err, 1);
        check("t4.err_code", err_code, 2);
        check("t4.count", count, 16);
        check("t4.done", done, 0);
        step();
        verify_writes("t4");

        // T5: HALT as the 16th token
        begin_test();
        do_start();
        for (int i = 0; i < 15; i++) tok(4'd0, 1'b0, 4'd0, 8'h00, 1);
        tok(4'd8, 1'b0, 4'd0, 8'hF0, 1);
        idle_in();
        check("t5.addr", imem_addr, 15);
        check("t5.data", imem_wdata, 8'hF0);
        check("t5.done", done, 1);
        check("t5.err", err, 0);
        check("t5.count", count, 16);
        step();
        verify_writes("t5");

        // T6: reset mid-load, restart, start ignored during LOAD
        begin_test();
        do_start();
        tok(4'd1, 1'b1, 4'd7, 8'h97, 1);
        tok(4'd2, 1'b1, 4'd2, 8'hA2, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_in();
        check_all_zero("t6.rst");
        step();
        verify_writes("t6a");
        begin_test();
        do_start();
        tok(4'd8, 1'b0, 4'd0, 8'hF0, 1);
        idle_in();
        check("t6.done", done, 1);
        check("t6.count", count, 1);
        step();
        verify_writes("t6b");
        begin_test();
        do_start();
        tok(4'd6, 1'b0, 4'd0, 8'h60, 1);
        idle_in();
        do_start();
        check("t6.busy_mid", busy, 1);
        check("t6.count_mid", count, 1);
        tok(4'd8, 1'b0, 4'd0, 8'hF0, 1);
        idle_in();
        check("t6.count_end", count, 2);
        step();
        verify_writes("t6c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
